// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//   Parallel-to-serial front end for the sequence detectors. Words of WIDTH
//   bits are taken over a valid/ready handshake into a one-entry pending
//   buffer, then shifted out MSB-first, one bit per clock, on ser_out.
//   A word waiting in the pending buffer is loaded on the same edge that ends
//   the previous frame, so back-to-back words form a continuous stream.
//
//   Optional feature: define SER_PARITY_EN to append one even-parity bit
//   (^word) after din[0]; the frame is then WIDTH+1 bits long. With the macro
//   undefined no parity logic exists and frames are payload only.
//
// Parameters
//   WIDTH       bits per word (2..32)
//   GAP_CYCLES  idle cycles inserted after every frame (0 = contiguous)
//   IDLE_LEVEL  level on ser_out whenever ser_valid is low
//   CNT_W       width of the words_sent counter
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   din         parallel word, din[WIDTH-1] is sent first
//   din_valid   upstream word valid
//   din_ready   a word can be accepted this cycle (pending buffer empty)
//   ser_out     registered serial bit to the detector
//   ser_valid   registered, ser_out carries a payload/parity bit
//   busy        frame in SHIFT or GAP, or pending buffer full
//   words_sent  completed frames, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
    parameter int   WIDTH      = 6,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    localparam int                BIT_W    = $clog2(FRAME);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME - 1);
    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Builds the on-wire frame for one word, MSB of the result goes out first.
    function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    state_t             state, state_d;
    logic [WIDTH-1:0]   pend;
    logic               pend_full, pend_full_d;
    logic [FRAME-1:0]   sreg, sreg_d;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
    logic [CNT_W-1:0]   words_sent_d;
    logic               ser_out_d, ser_valid_d;
    logic               accept, load;

    // Ready depends only on the buffer flag, never on din_valid.
    assign din_ready = ~pend_full;
    assign busy      = (state != IDLE) | pend_full;
    assign accept    = din_valid & ~pend_full;

    always_comb begin
        state_d      = state;
        pend_full_d  = pend_full;
        sreg_d       = sreg;
        bit_cnt_d    = bit_cnt;
        gap_cnt_d    = gap_cnt;
        words_sent_d = words_sent;
        load         = 1'b0;

        case (state)
            IDLE: begin
                if (pend_full) load = 1'b1;
            end
            SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    words_sent_d = words_sent + 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else if (pend_full) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                    sreg_d    = sreg << 1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (pend_full) load = 1'b1;
                    else           state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // load needs a full buffer and accept needs an empty one, so the two
        // never coincide.
        if (load) begin
            state_d     = SHIFT;
            sreg_d      = frame_of(pend);
            bit_cnt_d   = '0;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_full_d = 1'b1;
        end

        // Outputs are computed from next state so the flops present the bit
        // that belongs to the coming cycle.
        ser_valid_d = (state_d == SHIFT);
        ser_out_d   = ser_valid_d ? sreg_d[FRAME-1] : IDLE_LEVEL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_full  <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            words_sent <= '0;
            ser_valid  <= 1'b0;
            ser_out    <= IDLE_LEVEL;
        end else begin
            state      <= state_d;
            pend_full  <= pend_full_d;
            bit_cnt    <= bit_cnt_d;
            gap_cnt    <= gap_cnt_d;
            words_sent <= words_sent_d;
            ser_valid  <= ser_valid_d;
            ser_out    <= ser_out_d;
        end
    end

    // Payload storage carries no reset; it is qualified by pend_full/state.
    always_ff @(posedge clk) begin
        if (accept) pend <= din;
        sreg <= sreg_d;
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//   Directed bench. dut0 uses the default parameters; dut1 uses GAP_CYCLES=2,
//   IDLE_LEVEL=1 and a 2-bit words_sent counter to reach the wrap quickly.
//   A negedge collector records the valid bits of each stream, the longest
//   contiguous valid run, the idle run between frames and idle-level errors.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int          F1     = 7;
    localparam logic [31:0] T6_EXP = 32'b1110001_1110100;
`else
    localparam int          F1     = 6;
    localparam logic [31:0] T6_EXP = 32'b111000_111010;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] din0 = '0, din1 = '0;
    logic       din_valid0 = 1'b0, din_valid1 = 1'b0;
    logic       din_ready0, din_ready1;
    logic       ser_out0, ser_out1, ser_valid0, ser_valid1, busy0, busy1;
    logic [7:0] words_sent0;
    logic [1:0] words_sent1;

    seq_bit_serializer dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(din_valid0),
        .din_ready(din_ready0), .ser_out(ser_out0), .ser_valid(ser_valid0),
        .busy(busy0), .words_sent(words_sent0)
    );

    seq_bit_serializer #(.WIDTH(6), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1),
        .din_ready(din_ready1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .busy(busy1), .words_sent(words_sent1)
    );

    int n_vec = 0;
    int n_err = 0;
    int stalls = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream collectors
    logic        clr = 1'b0;
    logic [31:0] bits0, bits1;
    int          nbits0, nbits1, run0, maxrun0, idle1, gap1, idle_bad0, idle_bad1;

    always @(negedge clk) begin
        if (clr) begin
            bits0 <= '0; nbits0 <= 0; run0 <= 0; maxrun0 <= 0; idle_bad0 <= 0;
            bits1 <= '0; nbits1 <= 0; idle1 <= 0; gap1 <= 0; idle_bad1 <= 0;
        end else begin
            if (ser_valid0) begin
                bits0   <= {bits0[30:0], ser_out0};
                nbits0  <= nbits0 + 1;
                run0    <= run0 + 1;
                maxrun0 <= (run0 + 1 > maxrun0) ? run0 + 1 : maxrun0;
            end else begin
                run0 <= 0;
                if (ser_out0 !== 1'b0) idle_bad0 <= idle_bad0 + 1;
            end
            if (ser_valid1) begin
                if (nbits1 > 0 && idle1 > 0) gap1 <= idle1;
                idle1  <= 0;
                bits1  <= {bits1[30:0], ser_out1};
                nbits1 <= nbits1 + 1;
            end else begin
                idle1 <= idle1 + 1;
                if (ser_out1 !== 1'b1) idle_bad1 <= idle_bad1 + 1;
            end
        end
    end

    task automatic clear_log();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Offers a word and holds it until the edge that accepts it; returns at
    // #1 after that edge.
    task automatic send(input int which, input logic [5:0] w);
        logic acc;
        bit   done;
        done = 1'b0;
        if (which == 0) begin din0 = w; din_valid0 = 1'b1; end
        else            begin din1 = w; din_valid1 = 1'b1; end
        for (int i = 0; i < 100 && !done; i++) begin
            acc = (which == 0) ? din_ready0 : din_ready1;
            if (!acc) stalls++;
            @(posedge clk);
            #1 done = acc;
        end
        din_valid0 = 1'b0;
        din_valid1 = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int which);
        bit b;
        for (int i = 0; i < 300; i++) begin
            b = (which == 0) ? busy0 : busy1;
            if (!b) break;
            @(posedge clk);
            #1;
        end
        b = (which == 0) ? busy0 : busy1;
        if (b) check("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1 reset
        do_reset();
        check("t1_ser_valid",  32'(ser_valid0),  32'd0);
        check("t1_ser_out",    32'(ser_out0),    32'd0);
        check("t1_din_ready",  32'(din_ready0),  32'd1);
        check("t1_busy",       32'(busy0),       32'd0);
        check("t1_words_sent", 32'(words_sent0), 32'd0);
        check("t1_idle_level", 32'(ser_out1),    32'd1);

        // T2 single word with latency check
        clear_log();
        send(0, 6'b111010);
        check("t2_valid_at_accept", 32'(ser_valid0), 32'd0);
        @(posedge clk);
        #1;
        check("t2_first_valid", 32'(ser_valid0), 32'd1);
        check("t2_first_bit",   32'(ser_out0),   32'd1);
        wait_idle(0);
        check("t2_nbits",      32'(nbits0),      32'd6);
        check("t2_bits",       bits0,            32'b111010);
        check("t2_run",        32'(maxrun0),     32'd6);
        check("t2_words_sent", 32'(words_sent0), 32'd1);
        check("t2_ser_valid",  32'(ser_valid0),  32'd0);

        // T3 back-to-back, no bubble
        do_reset();
        clear_log();
        send(0, 6'b111010);
        send(0, 6'b111010);
        wait_idle(0);
        check("t3_nbits",      32'(nbits0),      32'd12);
        check("t3_bits",       bits0,            32'b111010_111010);
        check("t3_run",        32'(maxrun0),     32'd12);
        check("t3_words_sent", 32'(words_sent0), 32'd2);

        // T4 backpressure, three words
        do_reset();
        clear_log();
        stalls = 0;
        send(0, 6'b101100);
        send(0, 6'b010011);
        check("t4_ready_low", 32'(din_ready0), 32'd0);
        check("t4_busy",      32'(busy0),      32'd1);
        send(0, 6'b110001);
        wait_idle(0);
        check("t4_stalled",    32'(stalls > 0),  32'd1);
        check("t4_nbits",      32'(nbits0),      32'd18);
        check("t4_bits",       bits0,            32'b101100_010011_110001);
        check("t4_run",        32'(maxrun0),     32'd18);
        check("t4_words_sent", 32'(words_sent0), 32'd3);

        // T5 reset mid-frame
        clear_log();
        send(0, 6'b111010);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t5_mid_valid", 32'(ser_valid0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ser_valid",  32'(ser_valid0),  32'd0);
        check("t5_busy",       32'(busy0),       32'd0);
        check("t5_words_sent", 32'(words_sent0), 32'd0);
        rst = 1'b0;
        check("t5_din_ready",  32'(din_ready0),  32'd1);
        clear_log();
        send(0, 6'b100101);
        wait_idle(0);
        check("t5_nbits",      32'(nbits0),      32'd6);
        check("t5_bits",       bits0,            32'b100101);
        check("t5_words_after", 32'(words_sent0), 32'd1);
        check("t5_idle_level", 32'(idle_bad0),   32'd0);

        // T6 gap of two idle cycles between frames, parity when enabled
        clear_log();
        send(1, 6'b111000);
        send(1, 6'b111010);
        wait_idle(1);
        check("t6_nbits",      32'(nbits1),      32'(2 * F1));
        check("t6_bits",       bits1,            T6_EXP);
        check("t6_gap",        32'(gap1),        32'd2);
        check("t6_words_sent", 32'(words_sent1), 32'd2);
        check("t6_idle_level", 32'(idle_bad1),   32'd0);

        // words_sent wraps 3 -> 0
        send(1, 6'b000001);
        send(1, 6'b100000);
        wait_idle(1);
        check("wrap_words_sent", 32'(words_sent1), 32'd0);
        check("wrap_nbits",      32'(nbits1),      32'(4 * F1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
